// File: rtl/branch_resolver_if.sv
// branch_resolver_if: EX-stage branch operands in, PC redirect and flush controls out.
interface branch_resolver_if #(parameter int DATA_W = 32);
  logic              ex_valid;
  logic              ex_branch;
  logic              ex_prediction;
  logic [5:0]        ex_opcode;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_pc_plus4;
  logic [DATA_W-1:0] ex_imm;
  logic [25:0]       ex_jindex;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              flush_ifid;
  logic              flush_idex;
  modport master (
    output ex_valid, ex_branch, ex_prediction, ex_opcode, ex_rs_data, ex_rt_data,
           ex_pc_plus4, ex_imm, ex_jindex,
    input  redirect_valid, redirect_pc, flush_ifid, flush_idex
  );
  modport slave (
    input  ex_valid, ex_branch, ex_prediction, ex_opcode, ex_rs_data, ex_rt_data,
           ex_pc_plus4, ex_imm, ex_jindex,
    output redirect_valid, redirect_pc, flush_ifid, flush_idex
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: resolves BEQ/BNE/J/JAL in EX, redirects the PC and flushes IF/ID, ID/EX on mispredict.
// Define BRANCH_RESOLVER_STATS_EN to implement the saturating branch/mispredict counters.
module branch_resolver #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  branch_resolver_if.slave ex,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              rv_q, rv_d, fl_q, fl_d, busy_q, busy_d;
  logic              is_j, taken, resolve, mispredict;
  logic [DATA_W-1:0] target, fix_pc;
  always_comb begin
    is_j       = ex.ex_opcode == OP_J || ex.ex_opcode == OP_JAL;
    taken      = is_j || (ex.ex_opcode == OP_BEQ && ex.ex_rs_data == ex.ex_rt_data)
                      || (ex.ex_opcode == OP_BNE && ex.ex_rs_data != ex.ex_rt_data);
    target     = is_j ? {ex.ex_pc_plus4[DATA_W-1 -: DATA_W-28], ex.ex_jindex, 2'b00}
                      : ex.ex_pc_plus4 + (ex.ex_imm << 2);
    fix_pc     = taken ? target : ex.ex_pc_plus4;
    resolve    = state_q == IDLE && ex.ex_valid && ex.ex_branch && !stall_in;
    mispredict = resolve && (taken != ex.ex_prediction);
  end
  // REDIRECT counts as the first flush cycle; FLUSH covers the remaining FLUSH_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rv_d    = rv_q;
    fl_d    = fl_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (mispredict) begin
        state_d = REDIRECT;
        pc_d    = fix_pc;
        rv_d    = 1'b1;
        fl_d    = 1'b1;
        busy_d  = 1'b1;
      end
      REDIRECT: if (!stall_in) begin
        rv_d = 1'b0;
        if (FLUSH_CYCLES == 1) begin
          state_d = IDLE;
          fl_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: if (!stall_in) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          fl_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rv_d    = 1'b0;
        fl_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      rv_q    <= 1'b0;
      fl_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rv_q    <= rv_d;
      fl_q    <= fl_d;
      busy_q  <= busy_d;
    end
  end
  assign ex.redirect_valid = rv_q;
  assign ex.redirect_pc    = pc_q;
  assign ex.flush_ifid     = fl_q;
  assign ex.flush_idex     = fl_q;
  assign busy              = busy_q;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] bc_q, bc_d, mc_q, mc_d;
  always_comb begin
    bc_d = (resolve && !(&bc_q)) ? bc_q + 1'b1 : bc_q;
    mc_d = (mispredict && !(&mc_q)) ? mc_q + 1'b1 : mc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q <= '0;
      mc_q <= '0;
    end else begin
      bc_q <= bc_d;
      mc_q <= mc_d;
    end
  end
  assign branch_count     = bc_q;
  assign mispredict_count = mc_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: scoreboard bench; a flush-window model predicts per-cycle outputs and redirect targets.
module tb_branch_resolver;
  localparam int FC = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02, JAL = 6'h03, ADD = 6'h00;
`ifdef BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, stall_in = 1'b0, busy;
  logic [CW-1:0] bc, mc;
  branch_resolver_if #(.DATA_W(32)) bif ();
  branch_resolver #(.DATA_W(32), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .ex(bif), .busy(busy),
    .branch_count(bc), .mispredict_count(mc)
  );
  always #5 clk = ~clk;
  typedef struct {bit rv; bit fl; int bc; int mc;} exp_t;
  exp_t exp_q[$];
  logic [31:0] pc_q[$];
  int n_chk = 0, n_fail = 0;
  int rem = 0, m_bc = 0, m_mc = 0;
  bit mon_en = 1'b0, prev_rv = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // rem = flush cycles still owed; redirect shows only in the first of them.
  task automatic cyc(bit v, bit br, bit pr, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                     logic [31:0] pc4, logic [31:0] imm, logic [25:0] ji, bit st);
    exp_t e;
    bit taken, res;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    e.rv = (rem == FC);
    e.fl = (rem > 0);
    e.bc = STATS ? m_bc : 0;
    e.mc = STATS ? m_mc : 0;
    exp_q.push_back(e);
    bif.ex_valid = v; bif.ex_branch = br; bif.ex_prediction = pr; bif.ex_opcode = op;
    bif.ex_rs_data = rs; bif.ex_rt_data = rt; bif.ex_pc_plus4 = pc4; bif.ex_imm = imm;
    bif.ex_jindex = ji; stall_in = st;
    taken = (op == BEQ && rs == rt) || (op == BNE && rs != rt) || op == J || op == JAL;
    tgt = (op == J || op == JAL) ? {pc4[31:28], ji, 2'b00} : pc4 + imm * 4;
    res = rem == 0 && v && br && !st;
    if (rem > 0 && !st) rem--;
    if (res) begin
      if (m_bc < CMAX) m_bc++;
      if (taken != pr) begin
        if (m_mc < CMAX) m_mc++;
        rem = FC;
        pc_q.push_back(taken ? tgt : pc4);
      end
    end
  endtask
  task automatic idle(bit st);
    cyc(0, 0, 0, ADD, 0, 0, 0, 0, 0, st);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_rv"}, bif.redirect_valid, 0);
    chk({tag, "_pc"}, bif.redirect_pc, 0);
    chk({tag, "_flush_ifid"}, bif.flush_ifid, 0);
    chk({tag, "_flush_idex"}, bif.flush_idex, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bc"}, bc, 0);
    chk({tag, "_mc"}, mc, 0);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) prev_rv = 1'b0;
    else if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("redirect_valid", bif.redirect_valid, e.rv);
      chk("flush_ifid", bif.flush_ifid, e.fl);
      chk("flush_idex", bif.flush_idex, e.fl);
      chk("busy", busy, e.fl);
      chk("branch_count", bc, e.bc);
      chk("mispredict_count", mc, e.mc);
      if (bif.redirect_valid && !prev_rv) begin
        n_chk++;
        if (pc_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_redirect: got pc %0h expected none", bif.redirect_pc);
        end else chk("redirect_pc", bif.redirect_pc, pc_q.pop_front());
      end
      prev_rv = bif.redirect_valid;
    end
  end
  initial begin
    logic [5:0] ops [5];
    ops[0] = BEQ; ops[1] = BNE; ops[2] = J; ops[3] = JAL; ops[4] = ADD;
    bif.ex_valid = 0; bif.ex_branch = 0; bif.ex_prediction = 0; bif.ex_opcode = 0;
    bif.ex_rs_data = 0; bif.ex_rt_data = 0; bif.ex_pc_plus4 = 0; bif.ex_imm = 0; bif.ex_jindex = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc(1, 1, 0, BEQ, 5, 5, 32'h100, 3, 0, 0);
    repeat (4) idle(0);
    cyc(1, 1, 0, BNE, 7, 7, 32'h200, 9, 0, 0);
    repeat (2) idle(0);
    cyc(1, 1, 0, J, 0, 0, 32'h4000_0010, 0, 26'h40, 0);
    cyc(1, 1, 0, BEQ, 1, 1, 32'h300, 5, 0, 0);
    cyc(1, 1, 1, BNE, 1, 1, 32'h300, 5, 0, 0);
    repeat (3) idle(0);
    cyc(1, 1, 1, BEQ, 1, 2, 32'h500, 1, 0, 0);
    repeat (3) idle(1);
    repeat (4) idle(0);
    cyc(1, 1, 0, BNE, 1, 2, 32'h600, 32'hFFFF_FFFF, 0, 0);
    idle(0);
    @(negedge clk);
    chk("flush_before_reset", bif.flush_ifid, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    rem = 0; m_bc = 0; m_mc = 0;
    exp_q.delete(); pc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0, BEQ, 9, 9, 32'h800, 4, 0, 0);
    repeat (4) idle(0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, BEQ, 3, 4, 32'h900 + 32'(i * 16), 2, 0, 0);
      repeat (3) idle(0);
    end
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
          ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom & 32'hFFFF_FFFC, $urandom, 26'($urandom), $urandom_range(0, 3) == 0);
    repeat (6) idle(0);
    @(negedge clk);
    @(negedge clk);
    chk("pending_redirects", pc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
